// File: rtl/deck_controller_if.sv
// Deck controller bus: game requests, Shuffler handshake and the RAM port.
// master = game FSM / Shuffler / RAM side, slave = deck_controller.
interface deck_controller_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 4
);
  logic              new_game;
  logic              deal_req;
  logic              deal_ack;
  logic [DATA_W-1:0] card;
  logic              deck_empty;
  logic              busy;
  logic              act_shuffler;
  logic [ADDR_W-1:0] addr_j;
  logic              shuffled;
  logic [ADDR_W-1:0] shf_addr_i;
  logic [ADDR_W-1:0] shf_addr;
  logic [DATA_W-1:0] shf_data;
  logic              shf_mem_clk;
  logic              shf_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_clk;
  logic              write;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (
    output new_game, deal_req, shuffled, shf_addr_i, shf_addr, shf_data,
           shf_mem_clk, shf_write, mem_rd_data,
    input  deal_ack, card, deck_empty, busy, act_shuffler, addr_j,
           mem_addr, mem_data, mem_clk, write
  );

  modport slave (
    input  new_game, deal_req, shuffled, shf_addr_i, shf_addr, shf_data,
           shf_mem_clk, shf_write, mem_rd_data,
    output deal_ack, card, deck_empty, busy, act_shuffler, addr_j,
           mem_addr, mem_data, mem_clk, write
  );
endinterface

// File: rtl/deck_controller.sv
// Deck RAM sequencer: ordered init, Shuffler supervision, single-card deals.
// Optional feature macro: AUTO_RESHUFFLE_EN (deal request on empty deck reshuffles).
module deck_controller #(
  parameter int unsigned       DECK_SIZE = 52,
  parameter int unsigned       ADDR_W    = 6,
  parameter int unsigned       DATA_W    = 4,
  parameter logic [ADDR_W-1:0] LFSR_SEED = 6'h2D
) (
  input logic              clk,
  input logic              rst_n,
  deck_controller_if.slave bus
);

  localparam int unsigned       PTR_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DECK_SIZE - 1);
  localparam logic [ADDR_W-1:0] DECK_A    = ADDR_W'(DECK_SIZE);
  localparam logic [PTR_W-1:0]  DECK_END  = PTR_W'(DECK_SIZE);
  localparam logic [DATA_W-1:0] MAX_RANK  = DATA_W'(13);
  localparam logic [DATA_W-1:0] ACE       = DATA_W'(1);

  typedef enum logic [2:0] {
    IDLE, INIT_SETUP, INIT_WRITE, SHUF_RUN, READY, DEAL_SETUP, DEAL_READ, DEAL_CAP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic [PTR_W-1:0]  dptr;
  logic [ADDR_W-1:0] lfsr;
  logic [ADDR_W-1:0] j_next;
  logic [ADDR_W-1:0] prev_addr_i;
  logic [ADDR_W-1:0] addr_j_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              mem_clk_q;
  logic              write_q;
  logic              deal_ack_q;
  logic [DATA_W-1:0] card_q;
  logic              deck_empty_q;
  logic              busy_q;
  logic              act_q;
  logic              shuf_own;
`ifdef AUTO_RESHUFFLE_EN
  logic              pending_q;
`endif

  // Free-running x^6+x^5+1 swap-address source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[ADDR_W-2:0], lfsr[ADDR_W-1] ^ lfsr[ADDR_W-2]};
  end

  // Fold 52..63 back into range; a single subtract suffices since 63-52 < 52
  assign j_next = (lfsr >= DECK_A) ? lfsr - DECK_A : lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      init_ptr     <= '0;
      dptr         <= '0;
      prev_addr_i  <= '0;
      addr_j_q     <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_clk_q    <= 1'b0;
      write_q      <= 1'b0;
      deal_ack_q   <= 1'b0;
      card_q       <= '0;
      deck_empty_q <= 1'b0;
      busy_q       <= 1'b0;
      act_q        <= 1'b0;
`ifdef AUTO_RESHUFFLE_EN
      pending_q    <= 1'b0;
`endif
    end else begin
      deal_ack_q <= 1'b0;
      if (bus.new_game) begin
        // New game overrides everything, including an in-flight deal
        state      <= INIT_SETUP;
        init_ptr   <= '0;
        mem_addr_q <= '0;
        mem_data_q <= ACE;
        write_q    <= 1'b1;
        mem_clk_q  <= 1'b0;
        act_q      <= 1'b0;
        busy_q     <= 1'b1;
`ifdef AUTO_RESHUFFLE_EN
        pending_q  <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: ;
          INIT_SETUP: begin
            mem_clk_q <= 1'b1;
            state     <= INIT_WRITE;
          end
          INIT_WRITE: begin
            mem_clk_q <= 1'b0;
            if (init_ptr != LAST_ADDR) begin
              init_ptr   <= init_ptr + 1'b1;
              mem_addr_q <= init_ptr + 1'b1;
              mem_data_q <= (mem_data_q == MAX_RANK) ? ACE : mem_data_q + 1'b1;
              state      <= INIT_SETUP;
            end else begin
              write_q      <= 1'b0;
              mem_addr_q   <= '0;
              mem_data_q   <= '0;
              act_q        <= 1'b1;
              dptr         <= '0;
              deck_empty_q <= 1'b0;
              addr_j_q     <= j_next;
              prev_addr_i  <= bus.shf_addr_i;
              state        <= SHUF_RUN;
            end
          end
          SHUF_RUN: begin
            // New J only when the Shuffler moves on to its next I
            if (bus.shf_addr_i != prev_addr_i) begin
              addr_j_q    <= j_next;
              prev_addr_i <= bus.shf_addr_i;
            end
            if (bus.shuffled) begin
              act_q <= 1'b0;
`ifdef AUTO_RESHUFFLE_EN
              if (pending_q) begin
                pending_q  <= 1'b0;
                mem_addr_q <= ADDR_W'(dptr);
                state      <= DEAL_SETUP;
              end else begin
                busy_q <= 1'b0;
                state  <= READY;
              end
`else
              busy_q <= 1'b0;
              state  <= READY;
`endif
            end
          end
          READY: begin
            if (bus.deal_req) begin
              if (!deck_empty_q) begin
                mem_addr_q <= ADDR_W'(dptr);
                busy_q     <= 1'b1;
                state      <= DEAL_SETUP;
              end
`ifdef AUTO_RESHUFFLE_EN
              else begin
                act_q        <= 1'b1;
                dptr         <= '0;
                deck_empty_q <= 1'b0;
                pending_q    <= 1'b1;
                busy_q       <= 1'b1;
                addr_j_q     <= j_next;
                prev_addr_i  <= bus.shf_addr_i;
                state        <= SHUF_RUN;
              end
`endif
            end
          end
          DEAL_SETUP: begin
            mem_clk_q <= 1'b1;
            state     <= DEAL_READ;
          end
          DEAL_READ: begin
            mem_clk_q <= 1'b0;
            state     <= DEAL_CAP;
          end
          DEAL_CAP: begin
            card_q       <= bus.mem_rd_data;
            deal_ack_q   <= 1'b1;
            dptr         <= dptr + 1'b1;
            deck_empty_q <= ((dptr + 1'b1) == DECK_END);
            mem_addr_q   <= '0;
            busy_q       <= 1'b0;
            state        <= READY;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Shuffler owns the RAM port combinationally while it runs
  assign shuf_own = (state == SHUF_RUN);

  assign bus.mem_addr     = shuf_own ? bus.shf_addr    : mem_addr_q;
  assign bus.mem_data     = shuf_own ? bus.shf_data    : mem_data_q;
  assign bus.mem_clk      = shuf_own ? bus.shf_mem_clk : mem_clk_q;
  assign bus.write        = shuf_own ? bus.shf_write   : write_q;
  assign bus.deal_ack     = deal_ack_q;
  assign bus.card         = card_q;
  assign bus.deck_empty   = deck_empty_q;
  assign bus.busy         = busy_q;
  assign bus.act_shuffler = act_q;
  assign bus.addr_j       = addr_j_q;

endmodule

// File: tb/tb_deck_controller.sv
// Directed bench for deck_controller: RAM model, Shuffler stub, LFSR reference.
module tb_deck_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deck_controller_if #(.ADDR_W(6), .DATA_W(4)) ifc ();

  deck_controller dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  // Card RAM: write and read on rising MemClk
  logic [3:0] ram [64];
  logic [3:0] rd_q = 4'd0;
  always @(posedge ifc.mem_clk) begin
    if (ifc.write) ram[ifc.mem_addr] <= ifc.mem_data;
    rd_q <= ram[ifc.mem_addr];
  end
  assign ifc.mem_rd_data = rd_q;

  // Reference swap-address generator
  logic [5:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 6'h2D;
      m_prev <= 6'h2D;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
    end
  end

  function automatic logic [5:0] jmap(input logic [5:0] v);
    return (v >= 6'd52) ? v - 6'd52 : v;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] j;
  logic [3:0] a, b;
  int cnt;
  logic got_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(ifc.deal_ack), 0);
    chk({tag, "_card"},  32'(ifc.card), 0);
    chk({tag, "_empty"}, 32'(ifc.deck_empty), 0);
    chk({tag, "_busy"},  32'(ifc.busy), 0);
    chk({tag, "_act"},   32'(ifc.act_shuffler), 0);
    chk({tag, "_j"},     32'(ifc.addr_j), 0);
    chk({tag, "_addr"},  32'(ifc.mem_addr), 0);
    chk({tag, "_data"},  32'(ifc.mem_data), 0);
    chk({tag, "_mclk"},  32'(ifc.mem_clk), 0);
    chk({tag, "_wr"},    32'(ifc.write), 0);
  endtask

  task automatic wait_act(input int budget);
    int n = 0;
    while (ifc.act_shuffler !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("act_reached", 32'(ifc.act_shuffler), 1);
  endtask

  // Shuffler-side RAM access (Shuffler owns the port during SHUF_RUN)
  task automatic mem_op(input logic [5:0] addr, input logic [3:0] d, input logic w);
    ifc.shf_addr  = addr;
    ifc.shf_data  = d;
    ifc.shf_write = w;
    #1 ifc.shf_mem_clk = 1'b1;
    #1 ifc.shf_mem_clk = 1'b0;
    ifc.shf_write = 1'b0;
  endtask

  task automatic one_shot_game();
    ifc.new_game = 1'b1;
    tick();
    ifc.new_game = 1'b0;
  endtask

  initial begin
    ifc.new_game    = 1'b0;
    ifc.deal_req    = 1'b0;
    ifc.shuffled    = 1'b0;
    ifc.shf_addr_i  = '0;
    ifc.shf_addr    = '0;
    ifc.shf_data    = '0;
    ifc.shf_mem_clk = 1'b0;
    ifc.shf_write   = 1'b0;

    // Reset state
    #12;
    chk_all_zero("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Deal request in IDLE is ignored
    ifc.deal_req = 1'b1;
    tick();
    ifc.deal_req = 1'b0;
    repeat (3) begin
      tick();
      chk("idle_ack", 32'(ifc.deal_ack), 0);
    end
    chk("idle_busy", 32'(ifc.busy), 0);

    // Ordered init, 104 cycles to SHUF_RUN
    one_shot_game();
    chk("init_busy", 32'(ifc.busy), 1);
    chk("init_wr",   32'(ifc.write), 1);
    chk("init_addr", 32'(ifc.mem_addr), 0);
    chk("init_data", 32'(ifc.mem_data), 1);
    chk("init_mclk", 32'(ifc.mem_clk), 0);
    for (int c = 1; c < 104; c++) tick();
    chk("act_at_103", 32'(ifc.act_shuffler), 0);
    tick();
    chk("act_at_104", 32'(ifc.act_shuffler), 1);
    chk("j_entry", 32'(ifc.addr_j), 32'(jmap(m_prev)));
    chk("ram0",  32'(ram[0]), 1);
    chk("ram12", 32'(ram[12]), 13);
    chk("ram13", 32'(ram[13]), 1);
    chk("ram51", 32'(ram[51]), 13);

    // RAM port follows Shuffler combinationally
    ifc.shf_addr = 6'd37;
    #1 chk("shf_pass", 32'(ifc.mem_addr), 37);
    ifc.shf_addr = '0;

    // Shuffle driven by addr_j
    for (int i = 0; i < 52; i++) begin
      ifc.shf_addr_i = 6'(i);
      tick();
      tick();
      j = ifc.addr_j;
      chk("j_range", 32'(j < 6'd52), 1);
      mem_op(6'(i), 4'd0, 1'b0); a = rd_q;
      mem_op(j, 4'd0, 1'b0);     b = rd_q;
      mem_op(6'(i), b, 1'b1);
      mem_op(j, a, 1'b1);
      tick();
      chk("j_stable", 32'(ifc.addr_j), 32'(j));
    end
    ifc.shuffled = 1'b1;
    tick();
    ifc.shuffled = 1'b0;
    chk("rdy_act",   32'(ifc.act_shuffler), 0);
    chk("rdy_busy",  32'(ifc.busy), 0);
    chk("rdy_empty", 32'(ifc.deck_empty), 0);
    for (int v = 1; v <= 13; v++) begin
      cnt = 0;
      for (int k = 0; k < 52; k++) if (ram[k] == 4'(v)) cnt++;
      chk("rank_count", 32'(cnt), 4);
    end

    // 52 deals, ack exactly 3 cycles after the request
    for (int k = 0; k < 52; k++) begin
      chk("pre_empty", 32'(ifc.deck_empty), 0);
      ifc.deal_req = 1'b1;
      tick();
      ifc.deal_req = 1'b0;
      tick();
      tick();
      chk("ack_early", 32'(ifc.deal_ack), 0);
      tick();
      chk("ack", 32'(ifc.deal_ack), 1);
      chk("card", 32'(ifc.card), 32'(ram[k]));
    end
    chk("empty", 32'(ifc.deck_empty), 1);

    // Deal request with empty deck
`ifdef AUTO_RESHUFFLE_EN
    ifc.deal_req = 1'b1;
    tick();
    ifc.deal_req = 1'b0;
    chk("auto_act", 32'(ifc.act_shuffler), 1);
    chk("auto_empty", 32'(ifc.deck_empty), 0);
    tick();
    ifc.shuffled = 1'b1;
    tick();
    ifc.shuffled = 1'b0;
    chk("auto_act_off", 32'(ifc.act_shuffler), 0);
    got_ack = 1'b0;
    for (int n = 0; n < 8 && !got_ack; n++) begin
      tick();
      got_ack = ifc.deal_ack;
    end
    chk("auto_ack", 32'(got_ack), 1);
    chk("auto_card", 32'(ifc.card), 32'(ram[0]));
`else
    ifc.deal_req = 1'b1;
    tick();
    ifc.deal_req = 1'b0;
    repeat (4) begin
      tick();
      chk("empty_noack", 32'(ifc.deal_ack), 0);
    end
    chk("empty_busy", 32'(ifc.busy), 0);
    chk("empty_hold", 32'(ifc.deck_empty), 1);
`endif

    // New game during SHUF_RUN
    one_shot_game();
    wait_act(120);
    one_shot_game();
    chk("ng_shf_act",  32'(ifc.act_shuffler), 0);
    chk("ng_shf_addr", 32'(ifc.mem_addr), 0);
    chk("ng_shf_wr",   32'(ifc.write), 1);
    chk("ng_shf_data", 32'(ifc.mem_data), 1);

    // New game during DEAL_READ aborts the deal
    wait_act(120);
    ifc.shuffled = 1'b1;
    tick();
    ifc.shuffled = 1'b0;
    chk("ng_rdy_busy", 32'(ifc.busy), 0);
    ifc.deal_req = 1'b1;
    tick();
    ifc.deal_req = 1'b0;
    tick();
    chk("deal_read_mclk", 32'(ifc.mem_clk), 1);
    one_shot_game();
    chk("ng_deal_act",  32'(ifc.act_shuffler), 0);
    chk("ng_deal_ack",  32'(ifc.deal_ack), 0);
    chk("ng_deal_addr", 32'(ifc.mem_addr), 0);
    chk("ng_deal_wr",   32'(ifc.write), 1);
    repeat (3) begin
      tick();
      chk("ng_deal_noack", 32'(ifc.deal_ack), 0);
    end

    // Asynchronous reset mid-init, then LFSR restarts from its seed
    #3 rst_n = 1'b0;
    #1 chk_all_zero("arst");
    tick();
    rst_n = 1'b1;
    tick();
    one_shot_game();
    wait_act(120);
    chk("j_after_rst", 32'(ifc.addr_j), 32'(jmap(m_prev)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
